// File: rtl/axi_timer_averager_poller_if.sv
// AXI4-Lite point-to-point link between the timer-averager poller (master)
// and the averager register bank (slave).
interface axi_timer_averager_poller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_timer_averager_poller.sv
// AXI4-Lite master that turns fabric request pulses into fixed single-beat
// transaction sequences against the timer-averager register bank:
// STOP -> write 0x00, APPLY -> write 0x04, SNAP -> read 0x08/0x0C/0x10.
module axi_timer_averager_poller #(
    parameter int          M_AXI_LITE_DATA_WIDTH = 32,
    parameter int          M_AXI_LITE_ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR             = 32'h0,
    parameter int          TIMEOUT_CYCLES        = 1024
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        REQ_STOP,
    input  logic        REQ_APPLY,
    input  logic        REQ_SNAP,
    input  logic        CFG_ENABLE,
    input  logic [4:0]  CFG_LIMIT,
    input  logic        ERR_CLEAR,
    output logic [63:0] SNAP_AVG,
    output logic [31:0] SNAP_COUNT,
    output logic        SNAP_VALID,
    output logic        BUSY,
    output logic        ERR_RESP,
    output logic        ERR_TIMEOUT,
    axi_timer_averager_poller_if.master M_AXI_LITE
);

    localparam int AW = M_AXI_LITE_ADDR_WIDTH;
    localparam int DW = M_AXI_LITE_DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    typedef enum logic [1:0] {OP_STOP, OP_APPLY, OP_SNAP} op_t;

    // Register address = base + offset, wrapped to the bus address width.
    function automatic logic [AW-1:0] reg_addr(input logic [7:0] offset);
        logic [31:0] sum;
        sum = BASE_ADDR + {24'h0, offset};
        return AW'(sum);
    endfunction

    state_t          r_state;
    op_t             r_op;
    logic            r_pend_stop, r_pend_apply, r_pend_snap;
    logic [AW-1:0]   r_awaddr, r_araddr;
    logic [DW-1:0]   r_wdata;
    logic            r_awvalid, r_wvalid, r_aw_done, r_w_done, r_bready;
    logic            r_arvalid, r_rready;
    logic [1:0]      r_slot;
    logic [DW-1:0]   r_cap0, r_cap1, r_cap2;
    logic [63:0]     r_snap_avg;
    logic [31:0]     r_snap_count;
    logic            r_snap_valid;
    logic            r_err_resp, r_err_timeout;
    logic [TW-1:0]   r_tmo_cnt;

    logic w_idle, w_start_stop, w_start_apply, w_start_snap;
    logic w_aw_ok, w_w_ok, w_waiting, w_abort;

    // Arbitration in IDLE: STOP > APPLY > SNAP.
    assign w_idle        = (r_state == S_IDLE);
    assign w_start_stop  = w_idle && r_pend_stop;
    assign w_start_apply = w_idle && !r_pend_stop && r_pend_apply;
    assign w_start_snap  = w_idle && !r_pend_stop && !r_pend_apply && r_pend_snap;

    // A write channel counts as accepted once its handshake has happened,
    // either on an earlier cycle or on this one.
    assign w_aw_ok = r_aw_done || (r_awvalid && M_AXI_LITE.AWREADY);
    assign w_w_ok  = r_w_done  || (r_wvalid  && M_AXI_LITE.WREADY);

    // Flag cycles spent waiting on the slave; these feed the timeout counter.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_waiting = 1'b0;
        case (r_state)
            S_WR:      w_waiting = !(w_aw_ok && w_w_ok);
            S_WR_RESP: w_waiting = !M_AXI_LITE.BVALID;
            S_RD_ADDR: w_waiting = !M_AXI_LITE.ARREADY;
            S_RD_DATA: w_waiting = !M_AXI_LITE.RVALID;
            default:   w_waiting = 1'b0;
        endcase
    end

    assign w_abort = w_waiting && (r_tmo_cnt == TMO_LAST);

    // Latch request pulses; a pulse coinciding with its own start stays pending.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pend_stop  <= 1'b0;
            r_pend_apply <= 1'b0;
            r_pend_snap  <= 1'b0;
        end else begin
            r_pend_stop  <= (r_pend_stop  && !w_start_stop)  || REQ_STOP;
            r_pend_apply <= (r_pend_apply && !w_start_apply) || REQ_APPLY;
            r_pend_snap  <= (r_pend_snap  && !w_start_snap)  || REQ_SNAP;
        end
    end

    // Sequencer FSM: drives the AXI channels, captures read data, tracks errors.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state       <= S_IDLE;
            r_op          <= OP_STOP;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_wdata       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_slot        <= 2'd0;
            // NOTE: capture words are reset too, so a snapshot never exposes stale data.
            r_cap0        <= '0;
            r_cap1        <= '0;
            r_cap2        <= '0;
            r_snap_avg    <= '0;
            r_snap_count  <= '0;
            r_snap_valid  <= 1'b0;
            r_err_resp    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tmo_cnt     <= '0;
        end else begin
            r_snap_valid <= 1'b0;
            // Counter restarts on every state change because transitions only
            // happen on cycles that are not waiting.
            r_tmo_cnt    <= w_waiting ? r_tmo_cnt + 1'b1 : '0;

            // Clear comes first so a same-cycle error set below wins.
            if (ERR_CLEAR) begin
                r_err_resp    <= 1'b0;
                r_err_timeout <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_stop) begin
                        r_op      <= OP_STOP;
                        r_awaddr  <= reg_addr(8'h00);
                        r_wdata   <= DW'(32'h1);
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WR;
                    end else if (w_start_apply) begin
                        r_op      <= OP_APPLY;
                        r_awaddr  <= reg_addr(8'h04);
                        r_wdata   <= DW'({19'b0, CFG_LIMIT, 7'b0, CFG_ENABLE});
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WR;
                    end else if (w_start_snap) begin
                        r_op      <= OP_SNAP;
                        r_araddr  <= reg_addr(8'h08);
                        r_arvalid <= 1'b1;
                        r_slot    <= 2'd0;
                        r_state   <= S_RD_ADDR;
                    end
                end

                S_WR: begin
                    if (r_awvalid && M_AXI_LITE.AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && M_AXI_LITE.WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (M_AXI_LITE.BVALID) begin
                        r_bready <= 1'b0;
                        if (M_AXI_LITE.BRESP != 2'b00) r_err_resp <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_RD_ADDR: begin
                    if (M_AXI_LITE.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (M_AXI_LITE.RVALID) begin
                        r_rready <= 1'b0;
                        if (M_AXI_LITE.RRESP != 2'b00) r_err_resp <= 1'b1;
                        case (r_slot)
                            2'd0:    r_cap0 <= M_AXI_LITE.RDATA;
                            2'd1:    r_cap1 <= M_AXI_LITE.RDATA;
                            default: r_cap2 <= M_AXI_LITE.RDATA;
                        endcase
                        if (r_slot == 2'd2) begin
                            r_state <= S_DONE;
                        end else begin
                            r_slot    <= r_slot + 2'd1;
                            r_araddr  <= (r_slot == 2'd0) ? reg_addr(8'h0C) : reg_addr(8'h10);
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end

                S_DONE: begin
                    if (r_op == OP_SNAP) begin
                        r_snap_avg   <= {r_cap1, r_cap0};
                        r_snap_count <= r_cap2;
                        r_snap_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase

            // Hung-slave recovery overrides whatever the state branch chose.
            if (w_abort) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_err_timeout <= 1'b1;
                r_state       <= S_IDLE;
            end
        end
    end

    assign M_AXI_LITE.AWADDR  = r_awaddr;
    assign M_AXI_LITE.AWPROT  = 3'b000;
    assign M_AXI_LITE.AWVALID = r_awvalid;
    assign M_AXI_LITE.WDATA   = r_wdata;
    assign M_AXI_LITE.WSTRB   = '1;
    assign M_AXI_LITE.WVALID  = r_wvalid;
    assign M_AXI_LITE.BREADY  = r_bready;
    assign M_AXI_LITE.ARADDR  = r_araddr;
    assign M_AXI_LITE.ARPROT  = 3'b000;
    assign M_AXI_LITE.ARVALID = r_arvalid;
    assign M_AXI_LITE.RREADY  = r_rready;

    assign SNAP_AVG    = r_snap_avg;
    assign SNAP_COUNT  = r_snap_count;
    assign SNAP_VALID  = r_snap_valid;
    assign BUSY        = (r_state != S_IDLE);
    assign ERR_RESP    = r_err_resp;
    assign ERR_TIMEOUT = r_err_timeout;

endmodule

// File: tb/tb_axi_timer_averager_poller.sv
// Testbench for axi_timer_averager_poller: reactive AXI-Lite slave model,
// transaction and snapshot scoreboards, directed request sequence.
module tb_axi_timer_averager_poller;

    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        REQ_STOP, REQ_APPLY, REQ_SNAP;
    logic        CFG_ENABLE;
    logic [4:0]  CFG_LIMIT;
    logic        ERR_CLEAR;
    logic [63:0] SNAP_AVG;
    logic [31:0] SNAP_COUNT;
    logic        SNAP_VALID, BUSY, ERR_RESP, ERR_TIMEOUT;

    axi_timer_averager_poller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi_timer_averager_poller #(
        .M_AXI_LITE_DATA_WIDTH (32),
        .M_AXI_LITE_ADDR_WIDTH (32),
        .BASE_ADDR             (32'h0),
        .TIMEOUT_CYCLES        (TMO)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .REQ_STOP    (REQ_STOP),
        .REQ_APPLY   (REQ_APPLY),
        .REQ_SNAP    (REQ_SNAP),
        .CFG_ENABLE  (CFG_ENABLE),
        .CFG_LIMIT   (CFG_LIMIT),
        .ERR_CLEAR   (ERR_CLEAR),
        .SNAP_AVG    (SNAP_AVG),
        .SNAP_COUNT  (SNAP_COUNT),
        .SNAP_VALID  (SNAP_VALID),
        .BUSY        (BUSY),
        .ERR_RESP    (ERR_RESP),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .M_AXI_LITE  (axi)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [63:0] avg;
        logic [31:0] count;
    } snap_t;

    txn_t  sb_txn[$];
    snap_t sb_snap[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    int    n_snap_valid = 0;

    // Slave register contents and behaviour knobs.
    logic [31:0] reg08, reg0C, reg10;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          ar_block = 1'b0;
    int          rd_delay = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one slave-side handshake against the head of the transaction queue.
    task automatic sb_pop(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
        txn_t e;
        check("txn_expected", 64'(sb_txn.size() != 0), 64'(1));
        if (sb_txn.size() != 0) begin
            e = sb_txn.pop_front();
            check("txn_kind", 64'(is_wr), 64'(e.is_wr));
            check("txn_addr", 64'(addr), 64'(e.addr));
            if (is_wr) check("txn_wdata", 64'(data), 64'(e.data));
        end
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] addr);
        case (addr)
            32'h08:  return reg08;
            32'h0C:  return reg0C;
            32'h10:  return reg10;
            default: return 32'hBAD0_BAD0;
        endcase
    endfunction

    // AXI-Lite slave: decisions made on the falling edge from values sampled
    // on the previous falling edge, so handshakes are inferred exactly.
    initial begin : slave
        logic s_awv, s_awr, s_wv, s_bv, s_br, s_arv, s_arr, s_rv, s_rr;
        logic [31:0] s_awaddr, s_wdata, s_araddr, rd_addr;
        logic [2:0]  s_awprot, s_arprot;
        logic [3:0]  s_wstrb;
        bit          rd_pend;
        int          rd_wait;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BVALID = 1'b0;  axi.BRESP = 2'b00;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0;
        axi.RDATA = '0;     axi.RRESP = 2'b00;
        {s_awv, s_awr, s_wv, s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = '0;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0; rd_addr = '0;
        s_awprot = '0; s_arprot = '0; s_wstrb = '0;
        rd_pend = 1'b0; rd_wait = 0;
        forever begin
            @(negedge CLK);
            if (!RESETN) begin
                axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0;
                axi.ARREADY = 1'b0; axi.RVALID = 1'b0;
                {s_awv, s_awr, s_wv, s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = '0;
                rd_pend = 1'b0;
            end else begin
                if (s_awv && s_awr && s_wv) begin
                    sb_pop(1'b1, s_awaddr, s_wdata);
                    check("awprot", 64'(s_awprot), 64'(0));
                    check("wstrb", 64'(s_wstrb), 64'(4'hF));
                    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
                    axi.BVALID = 1'b1;  axi.BRESP = 2'b00;
                end else if (axi.AWVALID && axi.WVALID && !axi.AWREADY) begin
                    check("aw_ar_exclusive", 64'(axi.ARVALID), 64'(0));
                    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
                end
                if (s_bv && s_br) axi.BVALID = 1'b0;

                if (s_rv && s_rr) axi.RVALID = 1'b0;
                if (s_arv && s_arr) begin
                    sb_pop(1'b0, s_araddr, 32'h0);
                    check("arprot", 64'(s_arprot), 64'(0));
                    axi.ARREADY = 1'b0;
                    rd_addr = s_araddr;
                    if (rd_delay == 0) begin
                        axi.RVALID = 1'b1;
                        axi.RDATA  = slave_rd(rd_addr);
                        axi.RRESP  = (rd_addr == err_addr) ? 2'b10 : 2'b00;
                    end else begin
                        rd_pend = 1'b1;
                        rd_wait = rd_delay;
                    end
                end else begin
                    if (axi.ARVALID && !axi.ARREADY && !ar_block) axi.ARREADY = 1'b1;
                    if (rd_pend) begin
                        rd_wait--;
                        if (rd_wait == 0) begin
                            rd_pend    = 1'b0;
                            axi.RVALID = 1'b1;
                            axi.RDATA  = slave_rd(rd_addr);
                            axi.RRESP  = (rd_addr == err_addr) ? 2'b10 : 2'b00;
                        end
                    end
                end

                s_awv = axi.AWVALID; s_awr = axi.AWREADY; s_wv = axi.WVALID;
                s_bv = axi.BVALID;   s_br = axi.BREADY;
                s_arv = axi.ARVALID; s_arr = axi.ARREADY;
                s_rv = axi.RVALID;   s_rr = axi.RREADY;
                s_awaddr = axi.AWADDR; s_wdata = axi.WDATA;
                s_awprot = axi.AWPROT; s_wstrb = axi.WSTRB;
                s_araddr = axi.ARADDR; s_arprot = axi.ARPROT;
            end
        end
    end

    // Snapshot monitor: every SNAP_VALID strobe is checked against the queue.
    initial begin : snap_mon
        snap_t e;
        forever begin
            @(negedge CLK);
            if (RESETN && SNAP_VALID) begin
                n_snap_valid++;
                check("snap_expected", 64'(sb_snap.size() != 0), 64'(1));
                if (sb_snap.size() != 0) begin
                    e = sb_snap.pop_front();
                    check("snap_avg", SNAP_AVG, e.avg);
                    check("snap_count", 64'(SNAP_COUNT), 64'(e.count));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse(input bit stop, input bit apply, input bit snap);
        @(negedge CLK);
        REQ_STOP = stop; REQ_APPLY = apply; REQ_SNAP = snap;
        @(negedge CLK);
        REQ_STOP = 1'b0; REQ_APPLY = 1'b0; REQ_SNAP = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge CLK);
        ERR_CLEAR = 1'b1;
        @(negedge CLK);
        ERR_CLEAR = 1'b0;
    endtask

    // Wait until the block has been idle for several cycles (no pending work).
    task automatic wait_quiet(input string tag, input int budget);
        int idle_run = 0;
        int n = 0;
        while (idle_run < 4 && n < budget) begin
            @(negedge CLK);
            n++;
            if (BUSY) idle_run = 0;
            else      idle_run++;
        end
        check(tag, 64'(idle_run >= 4), 64'(1));
    endtask

    task automatic push_snap();
        sb_txn.push_back('{1'b0, 32'h08, 32'h0});
        sb_txn.push_back('{1'b0, 32'h0C, 32'h0});
        sb_txn.push_back('{1'b0, 32'h10, 32'h0});
        sb_snap.push_back('{{reg0C, reg08}, reg10});
    endtask

    initial begin : stim
        int base;
        int n;
        int cnt;
        bit found;
        RESETN = 1'b0;
        REQ_STOP = 1'b0; REQ_APPLY = 1'b0; REQ_SNAP = 1'b0;
        CFG_ENABLE = 1'b0; CFG_LIMIT = 5'd0; ERR_CLEAR = 1'b0;
        reg08 = 32'hDEAD_BEEF; reg0C = 32'h0000_0012; reg10 = 32'd42;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_valids", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID}), 64'(0));
        check("rst_readys", 64'({axi.BREADY, axi.RREADY}), 64'(0));
        check("rst_snap_valid", 64'(SNAP_VALID), 64'(0));
        check("rst_snap_avg", SNAP_AVG, 64'(0));
        check("rst_errs", 64'({ERR_RESP, ERR_TIMEOUT}), 64'(0));
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);

        // STOP: write 1 to 0x00
        sb_txn.push_back('{1'b1, 32'h00, 32'h1});
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("stop_busy", 64'(BUSY), 64'(1));
        wait_quiet("stop_done", 100);
        check("stop_txn_drained", 64'(sb_txn.size()), 64'(0));
        check("stop_err_resp", 64'(ERR_RESP), 64'(0));

        // APPLY: enable=1, limit=7 -> 0x0701; config changed after start
        CFG_ENABLE = 1'b1; CFG_LIMIT = 5'd7;
        sb_txn.push_back('{1'b1, 32'h04, 32'h0000_0701});
        pulse(1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        CFG_ENABLE = 1'b0; CFG_LIMIT = 5'd19;
        wait_quiet("apply_done", 100);
        check("apply_txn_drained", 64'(sb_txn.size()), 64'(0));

        // SNAP with RVALID delayed 2 cycles
        rd_delay = 2;
        push_snap();
        base = n_snap_valid;
        pulse(1'b0, 1'b0, 1'b1);
        wait_quiet("snap_done", 200);
        check("snap_pulses", 64'(n_snap_valid - base), 64'(1));
        check("snap_avg_value", SNAP_AVG, 64'h0000_0012_DEAD_BEEF);
        check("snap_count_value", 64'(SNAP_COUNT), 64'(42));
        check("snap_txn_drained", 64'(sb_txn.size() + sb_snap.size()), 64'(0));

        // All three at once, SNAP re-pulsed while busy -> STOP, APPLY, one SNAP
        rd_delay = 0;
        reg08 = 32'h1234_5678; reg0C = 32'h0000_0009; reg10 = 32'd100;
        CFG_ENABLE = 1'b0; CFG_LIMIT = 5'd31;
        sb_txn.push_back('{1'b1, 32'h00, 32'h1});
        sb_txn.push_back('{1'b1, 32'h04, 32'h0000_1F00});
        push_snap();
        base = n_snap_valid;
        pulse(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge CLK);
        pulse(1'b0, 1'b0, 1'b1);
        wait_quiet("combo_done", 300);
        check("combo_snap_pulses", 64'(n_snap_valid - base), 64'(1));
        check("combo_txn_drained", 64'(sb_txn.size() + sb_snap.size()), 64'(0));

        // Back-to-back: REQ_SNAP raised during DONE of a SNAP must be serviced
        rd_delay = 1;
        reg08 = 32'hCAFE_0001; reg0C = 32'h0000_0003; reg10 = 32'd7;
        push_snap();
        base = n_snap_valid;
        pulse(1'b0, 1'b0, 1'b1);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge CLK);
            n++;
            if (sb_txn.size() == 0 && BUSY && !axi.RREADY && !axi.ARVALID) found = 1'b1;
        end
        check("b2b_done_seen", 64'(found), 64'(1));
        if (found) begin
            push_snap();
            REQ_SNAP = 1'b1;
            @(negedge CLK);
            REQ_SNAP = 1'b0;
        end
        wait_quiet("b2b_done", 300);
        check("b2b_snap_pulses", 64'(n_snap_valid - base), 64'(2));
        check("b2b_txn_drained", 64'(sb_txn.size() + sb_snap.size()), 64'(0));

        // Error response on the 0x0C read still completes with a SNAP_VALID
        err_addr = 32'h0C;
        reg08 = 32'h0000_00AA; reg0C = 32'h0000_00BB; reg10 = 32'd5;
        push_snap();
        base = n_snap_valid;
        pulse(1'b0, 1'b0, 1'b1);
        wait_quiet("rresp_done", 200);
        err_addr = 32'hFFFF_FFFF;
        check("rresp_err_flag", 64'(ERR_RESP), 64'(1));
        check("rresp_snap_pulses", 64'(n_snap_valid - base), 64'(1));
        check("rresp_no_timeout", 64'(ERR_TIMEOUT), 64'(0));
        clear_err();
        check("rresp_cleared", 64'(ERR_RESP), 64'(0));

        // Hung slave: ARREADY never comes -> abort after TMO wait cycles
        ar_block = 1'b1;
        base = n_snap_valid;
        pulse(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!axi.ARVALID && n < 10) begin
            @(negedge CLK);
            n++;
        end
        cnt = 0;
        while (axi.ARVALID && cnt < 100) begin
            cnt++;
            @(negedge CLK);
        end
        check("tmo_arvalid_cycles", 64'(cnt), 64'(TMO));
        check("tmo_flag", 64'(ERR_TIMEOUT), 64'(1));
        check("tmo_idle", 64'(BUSY), 64'(0));
        check("tmo_rready", 64'(axi.RREADY), 64'(0));
        repeat (3) @(negedge CLK);
        check("tmo_no_snap", 64'(n_snap_valid - base), 64'(0));
        check("tmo_snap_kept", SNAP_AVG, 64'h0000_00BB_0000_00AA);
        ar_block = 1'b0;
        clear_err();
        check("tmo_cleared", 64'(ERR_TIMEOUT), 64'(0));

        // Reset asserted while waiting in RD_DATA
        rd_delay = 6;
        sb_txn.push_back('{1'b0, 32'h08, 32'h0});
        pulse(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!axi.RREADY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("rst_mid_reached_rd", 64'(axi.RREADY), 64'(1));
        RESETN = 1'b0;
        #1;
        check("rst_mid_busy", 64'(BUSY), 64'(0));
        check("rst_mid_rready", 64'(axi.RREADY), 64'(0));
        check("rst_mid_valids", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY}), 64'(0));
        check("rst_mid_snap_avg", SNAP_AVG, 64'(0));
        check("rst_mid_snap_count", 64'(SNAP_COUNT), 64'(0));
        check("rst_mid_flags", 64'({SNAP_VALID, ERR_RESP, ERR_TIMEOUT}), 64'(0));
        sb_txn.delete();
        sb_snap.delete();
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        rd_delay = 0;

        // Recovery: a plain STOP runs and no stale request reappears
        sb_txn.push_back('{1'b1, 32'h00, 32'h1});
        pulse(1'b1, 1'b0, 1'b0);
        wait_quiet("recover_done", 100);
        check("recover_txn_drained", 64'(sb_txn.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
